// File: rtl/replay_pkg.sv
// Shared types and helpers for the replay transmitter.
package replay_pkg;

  // Depth of the shipping configuration; ptr_t describes its pointers.
  localparam int unsigned N_DEF  = 8;
  localparam int unsigned AW_DEF = $clog2(N_DEF);

  // Widest pointer the window helper handles (depths up to 2^15).
  localparam int unsigned PTR_MAX_W = 16;

  typedef logic [PTR_MAX_W-1:0] ptr_wide_t;

  // Pointer split into wrap bit and buffer index.
  typedef struct packed {
    logic              o;
    logic [AW_DEF-1:0] p;
  } ptr_t;

  typedef enum logic {
    SEND   = 1'b0,
    REWIND = 1'b1
  } state_e;

  // True when q lies in [arch, spec) modulo 2^s_w, i.e. q names a word
  // that has been sent but not yet acknowledged.
  function automatic logic in_window(input ptr_wide_t   q,
                                     input ptr_wide_t   arch,
                                     input ptr_wide_t   spec,
                                     input int unsigned s_w);
    ptr_wide_t mask;
    ptr_wide_t dq;
    ptr_wide_t ds;
    mask = ptr_wide_t'((32'd1 << s_w) - 32'd1);
    dq   = (q - arch) & mask;
    ds   = (spec - arch) & mask;
    return dq < ds;
  endfunction

endpackage

// File: rtl/replay_tx_buf.sv
// Retention buffer: one write port, one asynchronous read port, no reset.
module replay_tx_buf #(
  parameter int unsigned W = 32,
  parameter int unsigned N = 8
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [$clog2(N)-1:0] wr_idx,
  input  logic [W-1:0]         wr_data,
  input  logic [$clog2(N)-1:0] rd_idx,
  output logic [W-1:0]         rd_data
);

  logic [W-1:0] mem_q [N];

  // Capture accepted upstream words; contents are only meaningful once written.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/replay_tx.sv
// Go-back-N link transmitter: buffers upstream words until cumulatively
// acknowledged and rewinds on NACK or ACK timeout.
//
//   state  | meaning
//   SEND   | present unsent buffered words on the link, in sequence order
//   REWIND | single idle link cycle after a NACK or timeout rewound spec
module replay_tx
  import replay_pkg::*;
#(
  parameter int unsigned W   = 32,
  parameter int unsigned N   = 8,
  parameter int unsigned TMO = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [W-1:0]       in,
  input  logic               in_vld,
  output logic               in_accept,
  output logic [W-1:0]       tx_data_r,
  output logic [$clog2(N):0] tx_seq_r,
  output logic               tx_vld_r,
  input  logic               tx_stall,
  input  logic               ack_vld,
  input  logic [$clog2(N):0] ack_seq,
  input  logic               nack_vld,
  input  logic [$clog2(N):0] nack_seq,
  output logic               err_r
);

  localparam int unsigned AW = $clog2(N);
  localparam int unsigned S  = AW + 1;
  localparam int unsigned TW = (TMO > 1) ? $clog2(TMO) : 1;

  // The timer counts down the remaining quiet cycles; reloading it is the
  // same as clearing an up-counting "cycles since progress" count.
  localparam logic [TW-1:0] TMR_LOAD = TW'(TMO - 1);
  localparam logic [S-1:0]  FULL_XOR = {1'b1, {AW{1'b0}}};

  logic [S-1:0]  wr_q, wr_d;
  logic [S-1:0]  arch_q, arch_d;
  logic [S-1:0]  spec_q, spec_d;
  logic [TW-1:0] tmr_q, tmr_d;
  state_e        state_q, state_d;
  logic [W-1:0]  tx_data_q, tx_data_d;
  logic [S-1:0]  tx_seq_q, tx_seq_d;
  logic          tx_vld_q, tx_vld_d;
  logic          err_q, err_d;

  logic          full;
  logic          pending;
  logic          outstanding;
  logic          wr_fire;
  logic          ack_ok;
  logic          nack_ok;
  logic          tmo_fire;
  logic          rewind_ev;
  logic          send_fire;
  logic [S-1:0]  arch_ack;
  logic [W-1:0]  rd_data;

  replay_tx_buf #(
    .W (W),
    .N (N)
  ) u_buf (
    .clk     (clk),
    .wr_en   (wr_fire),
    .wr_idx  (wr_q[AW-1:0]),
    .wr_data (in),
    .rd_idx  (spec_q[AW-1:0]),
    .rd_data (rd_data)
  );

  // Decode link events; a same-cycle NACK is judged against the post-ACK arch.
  always_comb begin
    full        = (wr_q ^ arch_q) == FULL_XOR;
    pending     = spec_q != wr_q;
    outstanding = arch_q != spec_q;
    wr_fire     = in_vld & ~full;
    ack_ok      = ack_vld & in_window(ptr_wide_t'(ack_seq), ptr_wide_t'(arch_q),
                                      ptr_wide_t'(spec_q), S);
    arch_ack    = ack_ok ? S'(ack_seq + 1'b1) : arch_q;
    nack_ok     = nack_vld & in_window(ptr_wide_t'(nack_seq), ptr_wide_t'(arch_ack),
                                       ptr_wide_t'(spec_q), S);
    tmo_fire    = outstanding & ~ack_ok & ~nack_ok & (tmr_q == '0);
    rewind_ev   = nack_ok | tmo_fire;
  end

  // FSM next state: any rewind event lands in (or stays in) REWIND.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SEND:    if (rewind_ev)  state_d = REWIND;
      REWIND:  if (!rewind_ev) state_d = SEND;
      default: state_d = SEND;
    endcase
  end

  // FSM outputs: link register load/hold/clear and the send strobe.
  always_comb begin
    tx_data_d = tx_data_q;
    tx_seq_d  = tx_seq_q;
    tx_vld_d  = tx_vld_q;
    send_fire = 1'b0;
    case (state_q)
      SEND: begin
        if (rewind_ev) begin
          // Drop whatever is on the link, stalled or not; spec is being rewritten.
          tx_vld_d = 1'b0;
        end else if (!(tx_vld_q && tx_stall)) begin
          if (pending) begin
            tx_data_d = rd_data;
            tx_seq_d  = spec_q;
            tx_vld_d  = 1'b1;
            send_fire = 1'b1;
          end else begin
            tx_vld_d = 1'b0;
          end
        end
      end
      REWIND: begin
        // Link is idle this cycle, so there is nothing for a stall to hold;
        // the first retransmission is loaded here to appear right after.
        if (rewind_ev) begin
          tx_vld_d = 1'b0;
        end else if (pending) begin
          tx_data_d = rd_data;
          tx_seq_d  = spec_q;
          tx_vld_d  = 1'b1;
          send_fire = 1'b1;
        end else begin
          tx_vld_d = 1'b0;
        end
      end
      default: tx_vld_d = 1'b0;
    endcase
  end

  // Pointer, timer and error bookkeeping.
  always_comb begin
    wr_d   = wr_fire ? S'(wr_q + 1'b1) : wr_q;
    arch_d = nack_ok ? nack_seq : arch_ack;

    if (nack_ok) begin
      spec_d = nack_seq;
    end else if (tmo_fire) begin
      spec_d = arch_q;
    end else if (send_fire) begin
      spec_d = S'(spec_q + 1'b1);
    end else begin
      spec_d = spec_q;
    end

    if (!outstanding || ack_ok || nack_ok || tmo_fire) begin
      tmr_d = TMR_LOAD;
    end else begin
      tmr_d = TW'(tmr_q - 1'b1);
    end

    err_d = err_q | (ack_vld & ~ack_ok) | (nack_vld & ~nack_ok);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= SEND;
    end else begin
      state_q <= state_d;
    end
  end

  // Control registers that need a known reset value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q     <= '0;
      arch_q   <= '0;
      spec_q   <= '0;
      tmr_q    <= TMR_LOAD;
      tx_vld_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      wr_q     <= wr_d;
      arch_q   <= arch_d;
      spec_q   <= spec_d;
      tmr_q    <= tmr_d;
      tx_vld_q <= tx_vld_d;
      err_q    <= err_d;
    end
  end

  // Link payload registers; only meaningful while tx_vld_r is high.
  always_ff @(posedge clk) begin
    tx_data_q <= tx_data_d;
    tx_seq_q  <= tx_seq_d;
  end

  assign in_accept = ~full;
  assign tx_data_r = tx_data_q;
  assign tx_seq_r  = tx_seq_q;
  assign tx_vld_r  = tx_vld_q;
  assign err_r     = err_q;

endmodule
